// File: rtl/d_flip_flop.sv
// rtl/d_flip_flop.sv - width-parameterisable D flip-flop with asynchronous active-high clear
module d_flip_flop #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             reset,
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // q comes straight from the register, so it cannot glitch between edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_d_flip_flop.sv
// tb/tb_d_flip_flop.sv - directed self-checking bench for d_flip_flop
`timescale 1ns/1ps
module tb_d_flip_flop;

  logic       clk;
  logic       reset;
  logic       d;
  logic       q;
  logic       reset8;
  logic [7:0] d8;
  logic [7:0] q8;
  int total;
  int bad;

  d_flip_flop u_dut1 (
    .reset(reset),
    .clk  (clk),
    .d    (d),
    .q    (q)
  );

  d_flip_flop #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .reset(reset8),
    .clk  (clk),
    .d    (d8),
    .q    (q8)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic at_time(input longint t);
    if (longint'($time) < t) #(t - longint'($time));
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    d = 1'b1;
    reset8 = 1'b1;
    d8 = 8'h3C;

    at_time(1);   check("w8_reset_value", q8, 8'hA5);
    at_time(15);  check("load_d1_first_edge", {7'd0, q}, 8'h01);
                  check("w8_reset_over_edge", q8, 8'hA5);
    at_time(25);  reset8 = 1'b0;
    at_time(29);  check("w8_release_no_change", q8, 8'hA5);
    at_time(31);  check("w8_load_3c", q8, 8'h3C);
    at_time(95);  check("hold_d1", {7'd0, q}, 8'h01);
    at_time(100); d = 1'b0;
    at_time(105); check("before_edge_110", {7'd0, q}, 8'h01);
    at_time(115); check("load_d0", {7'd0, q}, 8'h00);
    at_time(195); check("hold_d0", {7'd0, q}, 8'h00);
    at_time(200); reset = 1'b1; d = 1'b1;
    at_time(215); check("reset_ignores_d_edge210", {7'd0, q}, 8'h00);
    at_time(295); check("reset_ignores_d_edge290", {7'd0, q}, 8'h00);
    at_time(300); d = 1'b0;
    at_time(350); check("reset_d0", {7'd0, q}, 8'h00);
    at_time(400); reset = 1'b0; d = 1'b1;
    at_time(409); check("release_waits_edge", {7'd0, q}, 8'h00);
    at_time(411); check("load_after_release", {7'd0, q}, 8'h01);
    at_time(415); reset = 1'b1;
    at_time(416); check("async_assert_midcycle", {7'd0, q}, 8'h00);
    at_time(425); reset = 1'b0; d = 1'b1;
    at_time(429); check("midcycle_release_holds", {7'd0, q}, 8'h00);
    at_time(431); check("load_after_midcycle_release", {7'd0, q}, 8'h01);
    at_time(441); d = 1'b0;
    at_time(449); check("falling_edge_no_effect", {7'd0, q}, 8'h01);
    at_time(451); check("toggle_load0", {7'd0, q}, 8'h00);
    at_time(461); d = 1'b1;
    at_time(469); check("between_edges_hold", {7'd0, q}, 8'h00);
    at_time(471); check("toggle_load1", {7'd0, q}, 8'h01);
    at_time(481); d8 = 8'h5A;
    at_time(489); check("w8_hold_before_edge", q8, 8'h3C);
    at_time(490); reset = 1'b1;
    at_time(491); check("reset_wins_at_edge", {7'd0, q}, 8'h00);
                  check("w8_load_5a", q8, 8'h5A);
    at_time(495); reset8 = 1'b1;
    at_time(496); check("w8_async_reset", q8, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
